// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates deck shuffler driving a synchronous single-port deck RAM.
// Optional ordered-deck fill, LFSR-driven index selection with rejection sampling.
module deck_shuffler #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 6,
  parameter int DECK_SIZE = 52,
  parameter int RANKS     = 13
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              init_en,
  input  logic              abort,
  input  logic [15:0]       seed,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_PICK,
    S_RD_I,
    S_RD_J,
    S_CAP,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_e;

  localparam logic [15:0]       LFSR_MASK    = 16'hB400;
  localparam logic [15:0]       LFSR_DEFAULT = 16'hACE1;
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX      = ADDR_W'(1);
  localparam logic [DATA_W-1:0] RANK_FIRST   = DATA_W'(1);
  localparam logic [DATA_W-1:0] RANK_LAST    = DATA_W'(RANKS);

  state_e              state_q;
  logic [15:0]         lfsr_q;
  logic [15:0]         lfsr_d;
  logic [ADDR_W-1:0]   k_q;
  logic [DATA_W-1:0]   r_q;
  logic [ADDR_W-1:0]   i_q;
  logic [ADDR_W-1:0]   j_q;
  logic [DATA_W-1:0]   data_i_q;
  logic [DATA_W-1:0]   data_j_q;
  logic [ADDR_W-1:0]   cand;

  // Galois right-shift step; only committed while picking.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  assign cand   = lfsr_q[ADDR_W-1:0];

  // NOTE: every register here is updated with <= so all state advances from the same pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_DEFAULT;
      k_q      <= '0;
      r_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      data_i_q <= '0;
      data_j_q <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A simultaneous abort vetoes the launch.
          if (start && !abort) begin
            lfsr_q  <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
            k_q     <= '0;
            r_q     <= RANK_FIRST;
            i_q     <= LAST_IDX;
            state_q <= init_en ? S_INIT : S_PICK;
          end
        end
        S_INIT: begin
          k_q <= k_q + ONE_IDX;
          r_q <= (r_q == RANK_LAST) ? RANK_FIRST : r_q + RANK_FIRST;
          if (k_q == LAST_IDX) begin
            i_q     <= LAST_IDX;
            state_q <= S_PICK;
          end
        end
        S_PICK: begin
          lfsr_q <= lfsr_d;
          if (cand <= i_q) begin
            j_q     <= cand;
            state_q <= S_RD_I;
          end
        end
        S_RD_I: state_q <= S_RD_J;
        S_RD_J: begin
          data_i_q <= mem_rdata;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          data_j_q <= mem_rdata;
          state_q  <= S_WR_I;
        end
        S_WR_I: state_q <= S_WR_J;
        S_WR_J: begin
          if (i_q == ONE_IDX) begin
            state_q <= S_DONE;
          end else begin
            i_q     <= i_q - ONE_IDX;
            state_q <= S_PICK;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_addr  = k_q;
        mem_wdata = r_q;
        mem_wren  = 1'b1;
      end
      S_RD_I: mem_addr = i_q;
      S_RD_J: mem_addr = j_q;
      S_WR_I: begin
        mem_addr  = i_q;
        mem_wdata = data_j_q;
        mem_wren  = 1'b1;
      end
      S_WR_J: begin
        mem_addr  = j_q;
        mem_wdata = data_i_q;
        mem_wren  = 1'b1;
      end
      default: ;
    endcase
    // The cancelled cycle must not commit a write to the RAM.
    if (abort) mem_wren = 1'b0;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed self-checking bench: a 52-card and a 4-card shuffler, each with its own RAM,
// checked cycle by cycle against a software LFSR/Fisher-Yates model.
`timescale 1ns/1ps
module tb_deck_shuffler;

  typedef struct packed {
    logic       wren;
    logic [5:0] addr;
    logic [3:0] wdata;
    logic       busy;
    logic       done;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [2];
  logic        init_v  [2];
  logic        abort_v [2];
  logic [15:0] seed_v  [2];

  logic [5:0] addr_b;
  logic [3:0] wd_b, rd_b;
  logic       we_b, busy_b, done_b;
  logic [1:0] addr_s;
  logic [3:0] wd_s, rd_s;
  logic       we_s, busy_s, done_s;

  logic [3:0] ram_b [64];
  logic [3:0] ram_s [4];

  int   sel = 0;
  obs_t cur;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t       exp_q [$];
  obs_t       obs_q [$];
  int         pick_q [$];
  logic [3:0] deck_m [64];
  int         exp_done;

  always #5 clk = ~clk;

  deck_shuffler #(.DATA_W(4), .ADDR_W(6), .DECK_SIZE(52), .RANKS(13)) u_big (
    .clock(clk), .reset_n(rst_n), .start(start_v[0]), .init_en(init_v[0]),
    .abort(abort_v[0]), .seed(seed_v[0]), .mem_rdata(rd_b), .mem_addr(addr_b),
    .mem_wdata(wd_b), .mem_wren(we_b), .busy(busy_b), .done(done_b)
  );

  deck_shuffler #(.DATA_W(4), .ADDR_W(2), .DECK_SIZE(4), .RANKS(13)) u_small (
    .clock(clk), .reset_n(rst_n), .start(start_v[1]), .init_en(init_v[1]),
    .abort(abort_v[1]), .seed(seed_v[1]), .mem_rdata(rd_s), .mem_addr(addr_s),
    .mem_wdata(wd_s), .mem_wren(we_s), .busy(busy_s), .done(done_s)
  );

  always @(posedge clk) begin
    if (we_b) ram_b[addr_b] <= wd_b;
    rd_b <= ram_b[addr_b];
    if (we_s) ram_s[addr_s] <= wd_s;
    rd_s <= ram_s[addr_s];
  end

  always_comb begin
    cur = '0;
    if (sel == 0) begin
      cur.wren = we_b; cur.addr = addr_b; cur.wdata = wd_b;
      cur.busy = busy_b; cur.done = done_b;
    end else begin
      cur.wren = we_s; cur.addr = {4'b0000, addr_s}; cur.wdata = wd_s;
      cur.busy = busy_s; cur.done = done_s;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(input logic w, input int a, input int d, input logic b, input logic dn);
    obs_t o;
    o.wren = w; o.addr = 6'(a); o.wdata = 4'(d); o.busy = b; o.done = dn;
    return o;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Software reference: expected per-cycle outputs from the cycle after start, final deck, PICK cycles.
  task automatic build_model(input int n, input int aw, input logic [15:0] sd);
    logic [15:0] l;
    logic [3:0]  t;
    int          c;
    exp_q.delete();
    pick_q.delete();
    l = (sd == 16'h0000) ? 16'hACE1 : sd;
    for (int k = 0; k < n; k++) begin
      deck_m[k] = 4'((k % 13) + 1);
      exp_q.push_back(mk(1'b1, k, int'(deck_m[k]), 1'b1, 1'b0));
    end
    for (int i = n - 1; i >= 1; i--) begin
      do begin
        c = int'(l) & ((1 << aw) - 1);
        pick_q.push_back(exp_q.size() + 1);
        exp_q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
        l = lfsr_step(l);
      end while (c > i);
      exp_q.push_back(mk(1'b0, i, 0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, c, 0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, i, int'(deck_m[c]), 1'b1, 1'b0));
      exp_q.push_back(mk(1'b1, c, int'(deck_m[i]), 1'b1, 1'b0));
      t = deck_m[i]; deck_m[i] = deck_m[c]; deck_m[c] = t;
    end
    exp_q.push_back(mk(1'b0, 0, 0, 1'b1, 1'b1));
    exp_done = exp_q.size();
    repeat (3) exp_q.push_back(mk(1'b0, 0, 0, 1'b0, 1'b0));
  endtask

  // Launch one run on instance s and record outputs each cycle until 3 cycles past done,
  // one cycle past an abort, or the budget runs out.
  task automatic capture(input int s, input logic [15:0] sd, input bit hold, input int abort_at,
                         input int budget, output int done_cycle, output int ndone);
    obs_q.delete();
    done_cycle = -1;
    ndone = 0;
    sel = s;
    seed_v[s] = sd;
    init_v[s] = 1'b1;
    start_v[s] = 1'b1;
    tick();
    if (!hold) start_v[s] = 1'b0;
    for (int t = 1; t <= budget; t++) begin
      if (t == abort_at) abort_v[s] = 1'b1;
      #0;
      obs_q.push_back(cur);
      if (cur.done === 1'b1) begin
        ndone++;
        if (done_cycle < 0) done_cycle = t;
        start_v[s] = 1'b0;
      end
      if (t == abort_at) begin
        tick();
        abort_v[s] = 1'b0;
        start_v[s] = 1'b0;
        obs_q.push_back(cur);
        break;
      end
      if (done_cycle > 0 && t >= done_cycle + 3) break;
      tick();
    end
    start_v[s] = 1'b0;
  endtask

  function automatic int trace_errs(input int upto, output int first);
    int e = 0;
    first = -1;
    for (int t = 0; t < upto && t < obs_q.size() && t < exp_q.size(); t++) begin
      if (obs_q[t].wren !== exp_q[t].wren || obs_q[t].addr !== exp_q[t].addr ||
          obs_q[t].busy !== exp_q[t].busy || obs_q[t].done !== exp_q[t].done ||
          (exp_q[t].wren && obs_q[t].wdata !== exp_q[t].wdata)) begin
        e++;
        if (first < 0) first = t + 1;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    sel = 0;
    n_checks++;
    if ({busy_b, done_b, we_b, addr_b, wd_b} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_big_outputs: got %b, want all zero", {busy_b, done_b, we_b, addr_b, wd_b});
    end
    n_checks++;
    if ({busy_s, done_s, we_s, addr_s, wd_s} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_small_outputs: got %b, want all zero", {busy_s, done_s, we_s, addr_s, wd_s});
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy_b !== 1'b0 || busy_s !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy big=%b small=%b, want 0", busy_b, busy_s);
    end
  endtask

  task automatic test_reset_mid_init();
    sel = 0;
    seed_v[0] = 16'h0001;
    init_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (we_b !== 1'b1 || addr_b !== 6'd10 || wd_b !== 4'd11) begin
      n_fail++;
      $display("FAIL init_k10: got wren=%b addr=%0d wdata=%0d, want 1/10/11", we_b, addr_b, wd_b);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_b, done_b, we_b, addr_b, wd_b} !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got %b, want all zero", {busy_b, done_b, we_b, addr_b, wd_b});
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (busy_b !== 1'b0 || we_b !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_release: busy=%b wren=%b, want 0/0", busy_b, we_b);
    end
  endtask

  task automatic test_full_run();
    int dc, nd, first, e;
    int hist [14];
    build_model(52, 6, 16'h0001);
    capture(0, 16'h0001, 1'b0, -1, 5000, dc, nd);
    n_checks++;
    if (dc !== exp_done) begin
      n_fail++;
      $display("FAIL big_done_cycle: got %0d, want %0d", dc, exp_done);
    end
    e = trace_errs(52, first);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL big_init_writes: %0d bad cycles (first %0d), want 0", e, first);
    end
    e = trace_errs(exp_q.size(), first);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL big_trace: %0d bad cycles (first %0d), want 0", e, first);
    end
    for (int v = 0; v < 14; v++) hist[v] = 0;
    for (int a = 0; a < 52; a++) begin
      n_checks++;
      if (ram_b[a] !== deck_m[a]) begin
        n_fail++;
        $display("FAIL big_deck[%0d]: got %0d, want %0d", a, ram_b[a], deck_m[a]);
      end
      if (ram_b[a] >= 4'd1 && ram_b[a] <= 4'd13) hist[ram_b[a]]++;
    end
    for (int v = 1; v <= 13; v++) begin
      n_checks++;
      if (hist[v] !== 4) begin
        n_fail++;
        $display("FAIL big_count_of_%0d: got %0d, want 4", v, hist[v]);
      end
    end
  endtask

  task automatic test_seed_zero();
    int dc0, dc1, nd, first, e, nw;
    logic [3:0] hand [4];
    // 1,2,3,4 -> swap(3,1) -> swap(2,0) -> swap(1,0), one PICK each, done at cycle 4+3*6+1.
    hand[0] = 4'd4; hand[1] = 4'd3; hand[2] = 4'd1; hand[3] = 4'd2;
    build_model(4, 2, 16'h0000);
    for (int run = 0; run < 2; run++) begin
      capture(1, (run == 0) ? 16'h0000 : 16'hACE1, 1'b0, -1, 500, dc1, nd);
      if (run == 0) dc0 = dc1;
      n_checks++;
      if (dc1 !== 23) begin
        n_fail++;
        $display("FAIL small_done_cycle_run%0d: got %0d, want 23", run, dc1);
      end
      e = trace_errs(exp_q.size(), first);
      n_checks++;
      if (e !== 0) begin
        n_fail++;
        $display("FAIL small_trace_run%0d: %0d bad cycles (first %0d), want 0", run, e, first);
      end
      nw = 0;
      foreach (obs_q[t]) if (obs_q[t].wren === 1'b1) nw++;
      n_checks++;
      if (nw !== 10) begin
        n_fail++;
        $display("FAIL small_write_count_run%0d: got %0d, want 10 (4 init + 3 swaps)", run, nw);
      end
      for (int a = 0; a < 4; a++) begin
        n_checks++;
        if (ram_s[a] !== hand[a]) begin
          n_fail++;
          $display("FAIL small_deck_run%0d[%0d]: got %0d, want %0d", run, a, ram_s[a], hand[a]);
        end
      end
    end
    n_checks++;
    if (dc1 !== dc0) begin
      n_fail++;
      $display("FAIL seed0_vs_ace1_cycles: got %0d, want %0d", dc1, dc0);
    end
  endtask

  task automatic test_back_to_back();
    int dc_single, dc_hold, nd, first, e;
    build_model(4, 2, 16'h1234);
    capture(1, 16'h1234, 1'b0, -1, 500, dc_single, nd);
    capture(1, 16'h1234, 1'b1, -1, 500, dc_hold, nd);
    n_checks++;
    if (dc_hold !== dc_single) begin
      n_fail++;
      $display("FAIL held_start_cycles: got %0d, want %0d", dc_hold, dc_single);
    end
    n_checks++;
    if (dc_hold !== exp_done) begin
      n_fail++;
      $display("FAIL held_start_vs_model: got %0d, want %0d", dc_hold, exp_done);
    end
    n_checks++;
    if (nd !== 1) begin
      n_fail++;
      $display("FAIL held_start_done_count: got %0d, want 1", nd);
    end
    e = trace_errs(exp_q.size(), first);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL held_start_trace: %0d bad cycles (first %0d), want 0", e, first);
    end
  endtask

  task automatic test_abort();
    int dc, nd, first, e, at;
    obs_t o;
    build_model(52, 6, 16'h00A5);
    at = pick_q[4];
    capture(0, 16'h00A5, 1'b0, at, 5000, dc, nd);
    e = trace_errs(at, first);
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL abort_prefix_trace: %0d bad cycles (first %0d), want 0", e, first);
    end
    o = obs_q[obs_q.size() - 1];
    n_checks++;
    if (o.busy !== 1'b0 || o.wren !== 1'b0 || o.done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort: busy=%b wren=%b done=%b, want 0/0/0", o.busy, o.wren, o.done);
    end
    n_checks++;
    if (nd !== 0) begin
      n_fail++;
      $display("FAIL abort_done_count: got %0d, want 0", nd);
    end
    tick();
    n_checks++;
    if (busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stays_idle: busy=%b, want 0", busy_b);
    end
    capture(0, 16'h00A5, 1'b0, -1, 5000, dc, nd);
    n_checks++;
    if (dc !== exp_done) begin
      n_fail++;
      $display("FAIL restart_done_cycle: got %0d, want %0d", dc, exp_done);
    end
    e = 0;
    for (int a = 0; a < 52; a++) if (ram_b[a] !== deck_m[a]) e++;
    n_checks++;
    if (e !== 0) begin
      n_fail++;
      $display("FAIL restart_deck: %0d words differ, want 0", e);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      init_v[s]  = 1'b1;
      abort_v[s] = 1'b0;
      seed_v[s]  = 16'h0000;
    end
    repeat (3) tick();
    test_reset();
    test_reset_mid_init();
    test_full_run();
    test_seed_zero();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deck_shuffler.md
# deck_shuffler

Parametrised in-place deck shuffler for the card-game datapath. It sits between the game FSM and the deck RAM. On a `start` pulse it optionally loads an ordered deck into RAM, then permutes the deck with a Fisher–Yates shuffle. Random indices come from a seeded 16-bit LFSR. It reports `busy`/`done` back to the FSM.

## Interface
Parameters:
- `DATA_W`, 4, width of one card word in RAM
- `ADDR_W`, 6, RAM address width
- `DECK_SIZE`, 52, number of cards; legal range 2 ≤ DECK_SIZE ≤ 2^ADDR_W
- `RANKS`, 13, rank count used by the init fill; legal range 1 ≤ RANKS < 2^DATA_W

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: launch request; sampled only in IDLE.
- `init_en`, in, 1: sampled with `start`; 1 = fill the ordered deck before shuffling.
- `abort`, in, 1: synchronous cancel.
- `seed`, in, 16: LFSR seed, sampled with `start`.
- `mem_rdata`, in, DATA_W: RAM read data, valid 1 cycle after its address.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_wdata`, out, DATA_W: RAM write data.
- `mem_wren`, out, 1: RAM write enable.
- `busy`, out, 1: high from the cycle after an accepted `start` through DONE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- States: IDLE, INIT, PICK, RD_I, RD_J, CAP, WR_I, WR_J, DONE.
- Counters:
  - `k`: INIT address.
  - `r`: rank counter.
  - `i`: shuffle top, ADDR_W bits.
  - `j`: chosen index.
- Data registers `data_i`, `data_j`.
- LFSR `lfsr[15:0]`:
  - Galois, right-shift, mask 16'hB400: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Loaded from `seed` on accepted `start`; a seed of 0 loads 16'hACE1.
- IDLE: `start`=1 → latch `seed`/`init_en`. Next state is INIT (k=0, r=1) if `init_en`, else PICK with i=DECK_SIZE-1.
- INIT:
  - Each cycle: mem_addr=k, mem_wdata=r, mem_wren=1.
  - k increments. r increments, wrapping from RANKS back to 1.
  - After writing k=DECK_SIZE-1 → PICK with i=DECK_SIZE-1.
- PICK:
  - Candidate c = lfsr[ADDR_W-1:0].
  - The LFSR advances every PICK cycle.
  - If c ≤ i: j=c → RD_I. Otherwise stay in PICK (rejection sampling, no modulo).
- RD_I: mem_addr=i, read.
- RD_J: mem_addr=j; data_i ← mem_rdata.
- CAP: data_j ← mem_rdata.
- WR_I: mem_addr=i, mem_wdata=data_j, mem_wren=1.
- WR_J:
  - mem_addr=j, mem_wdata=data_i, mem_wren=1.
  - If i==1 → DONE; otherwise i ← i-1 → PICK.
- j==i is legal; the same word is written back twice.
- DONE: done=1, busy=1 for one cycle → IDLE.
- mem_addr, mem_wdata and mem_wren are decoded from state/counters. In IDLE, PICK, CAP and DONE: mem_wren=0, mem_addr=0, mem_wdata=0. The LFSR does not advance outside PICK.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE; no `done`; mem_wren=0 in the abort cycle.
  - A swap interrupted between WR_I and WR_J may leave a duplicated card. The game FSM must re-run with init_en=1.
- `start` while busy is ignored. `abort` in IDLE has no effect. `abort` has priority over `start`.

## Timing
- Reset (async, immediate):
  - State=IDLE.
  - busy=0, done=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - LFSR=16'hACE1; counters=0.
- Reset deasserted mid-operation: the block restarts cleanly in IDLE.
- RAM model: synchronous read, 1-cycle latency, write on the clock edge with mem_wren.
- Start-to-busy: 1 cycle.
- Init phase: exactly DECK_SIZE cycles.
- Per swap: P + 5 cycles, where P ≥ 1 is the number of PICK cycles.
- Total swaps: DECK_SIZE-1.
- `done` asserts 1 cycle after the final WR_J. `busy` deasserts the cycle after `done`.
- Worst-case PICK run is bounded by the LFSR period (65535).

## Test plan
- Reset mid-INIT (reset_n low for 1 cycle at k=10) → outputs 0 immediately; IDLE after release; a following start runs normally.
- Defaults, seed=16'h0001, init_en=1 → 52 INIT writes of 1,2,…,13,1,… in cycles 1–52. After done, RAM holds exactly four of each value 1–13, and contents match a bit-exact software model of the LFSR and Fisher–Yates.
- DECK_SIZE=4, ADDR_W=2, seed=16'h0000, init_en=1 → behaves identically to seed=16'hACE1. The write sequence and cycle count match the model. Exactly 3 WR_J writes.
- `start` pulsed every cycle while busy → no restart; exactly one `done`; total cycle count equals a single-start run.
- `abort` asserted during the 5th PICK state → busy=0 and mem_wren=0 the next cycle, no `done`. A restart with the same seed gives the same final deck as an uninterrupted run.
